// File: rtl/halt_seq_pkg.sv
// rtl/halt_seq_pkg.sv - shared states, encodings and status-register constants for halt_sequencer
// HALTSEQ_RESET_CMD_EN decides whether op 11 (RESET_HALT) is a supported command.
package halt_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_SETUP,
        S_RD_ACCESS,
        S_DECIDE,
        S_WR_SETUP,
        S_WR_ACCESS,
        S_WR_TURN,
        S_POLL_SETUP,
        S_POLL_ACCESS,
        S_CHECK,
        S_GAP,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_ACCESS
    } xfer_phase_e;

    localparam logic [1:0] OP_NONE       = 2'b00;
    localparam logic [1:0] OP_HALT       = 2'b01;
    localparam logic [1:0] OP_RESUME     = 2'b10;
    localparam logic [1:0] OP_RESET_HALT = 2'b11;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_TIMEOUT = 2'b01;
    localparam logic [1:0] RSP_BADCMD  = 2'b10;

    localparam int DBG_REQ = 0;
    localparam int DBG_ACK = 1;
    localparam int RST_REQ = 2;
    localparam int HALTED  = 3;

    localparam logic [7:0] TOGGLE_DBG = 8'h01;
    localparam logic [7:0] PULSE_RST  = 8'h04;

    function automatic logic op_supported(input logic [1:0] op);
`ifdef HALTSEQ_RESET_CMD_EN
        return op != OP_NONE;
`else
        return (op != OP_NONE) && (op != OP_RESET_HALT);
`endif
    endfunction

endpackage

// File: rtl/halt_sequencer_if.sv
// rtl/halt_sequencer_if.sv - APB link between halt_sequencer and the status register slave
interface halt_sequencer_if;
    logic       M_PSEL;
    logic       M_PENABLE;
    logic       M_PWRITE;
    logic [4:0] M_PADDR;
    logic [7:0] M_PWDATA;
    logic [7:0] M_PRDATA;
    logic       M_PREADY;

    modport master (
        output M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA,
        input  M_PRDATA, M_PREADY
    );

    modport slave (
        input  M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA,
        output M_PRDATA, M_PREADY
    );
endinterface

// File: rtl/halt_sequencer_apb_xfer.sv
// rtl/halt_sequencer_apb_xfer.sv - single-transfer APB master engine (setup, access, done)
module apb_xfer
    import halt_seq_pkg::*;
#(
    parameter logic [4:0] ADDR = 5'h00
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             write_i,
    input  logic [7:0]       wdata_i,
    output logic             done_o,
    output logic [7:0]       rdata_o,
    halt_sequencer_if.master apb
);

    xfer_phase_e phase_q, phase_d;
    logic        write_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;

    always_comb begin
        phase_d = phase_q;
        unique case (phase_q)
            X_IDLE:   if (start_i) phase_d = X_SETUP;
            X_SETUP:  phase_d = X_ACCESS;
            X_ACCESS: if (apb.M_PREADY) phase_d = X_IDLE;
            default:  phase_d = X_IDLE;
        endcase
    end

    // Direction and data are captured once so they stay stable through setup and access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= X_IDLE;
            write_q <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            phase_q <= phase_d;
            if (phase_q == X_IDLE && start_i) begin
                write_q <= write_i;
                wdata_q <= wdata_i;
            end
            if (done_o && !write_q) begin
                rdata_q <= apb.M_PRDATA;
            end
        end
    end

    assign done_o        = (phase_q == X_ACCESS) && apb.M_PREADY;
    assign rdata_o       = rdata_q;
    assign apb.M_PSEL    = (phase_q != X_IDLE);
    assign apb.M_PENABLE = (phase_q == X_ACCESS);
    assign apb.M_PWRITE  = write_q;
    assign apb.M_PWDATA  = wdata_q;
    assign apb.M_PADDR   = ADDR;

endmodule

// File: rtl/halt_sequencer.sv
// rtl/halt_sequencer.sv - halt/resume/reset-halt command sequencer over the debug status register
// Define HALTSEQ_RESET_CMD_EN to build the RESET_HALT (op 11) command.
module halt_sequencer
    import halt_seq_pkg::*;
#(
    parameter logic [4:0]  STATUS_ADDR    = 5'h00,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned POLL_GAP       = 4
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    output logic             rsp_valid,
    output logic [1:0]       rsp_status,
    output logic             busy,
    halt_sequencer_if.master m
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;

    state_e        state_q, state_d;
    logic [1:0]    op_q;
    logic [1:0]    status_q, status_d;
    logic [TW-1:0] tmo_q;
    logic [15:0]   gap_q;
    logic          x_start, x_write, x_done;
    logic [7:0]    x_wdata, x_rdata;
    logic          wr_need, poll_ok, tmo_hit;
    logic [7:0]    wr_val;
    logic          unused_rdata;

    apb_xfer #(.ADDR(STATUS_ADDR)) u_xfer (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .start_i (x_start),
        .write_i (x_write),
        .wdata_i (x_wdata),
        .done_o  (x_done),
        .rdata_o (x_rdata),
        .apb     (m)
    );

    // x_rdata holds the initial read in DECIDE and the latest poll in CHECK.
    always_comb begin
        wr_need = 1'b0;
        wr_val  = TOGGLE_DBG;
        poll_ok = 1'b0;
        case (op_q)
            OP_HALT: begin
                wr_need = ~x_rdata[DBG_REQ];
                poll_ok = x_rdata[DBG_ACK] & x_rdata[HALTED];
            end
            OP_RESUME: begin
                wr_need = x_rdata[DBG_REQ];
                poll_ok = ~x_rdata[DBG_ACK];
            end
`ifdef HALTSEQ_RESET_CMD_EN
            OP_RESET_HALT: begin
                wr_need = 1'b1;
                wr_val  = PULSE_RST | {7'b0, ~x_rdata[DBG_REQ]};
                poll_ok = ~x_rdata[RST_REQ] & x_rdata[DBG_ACK] & x_rdata[HALTED];
            end
`endif
            default: ;
        endcase
    end

    assign tmo_hit      = (tmo_q >= TW'(TIMEOUT_CYCLES));
    assign unused_rdata = ^{x_rdata[7:4], x_rdata[RST_REQ]};

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        x_start  = 1'b0;
        x_write  = 1'b0;
        x_wdata  = 8'h00;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (op_supported(cmd_op)) begin
                        x_start = 1'b1;
                        state_d = S_RD_SETUP;
                    end else begin
                        status_d = RSP_BADCMD;
                        state_d  = S_DONE;
                    end
                end
            end
            S_RD_SETUP:  state_d = S_RD_ACCESS;
            S_RD_ACCESS: if (x_done) state_d = S_DECIDE;
            S_DECIDE: begin
                x_start = 1'b1;
                if (wr_need) begin
                    x_write = 1'b1;
                    x_wdata = wr_val;
                    state_d = S_WR_SETUP;
                end else begin
                    state_d = S_POLL_SETUP;
                end
            end
            S_WR_SETUP:  state_d = S_WR_ACCESS;
            S_WR_ACCESS: if (x_done) state_d = S_WR_TURN;
            // Idle cycle so PSEL drops between the write and the first poll.
            S_WR_TURN: begin
                x_start = 1'b1;
                state_d = S_POLL_SETUP;
            end
            S_POLL_SETUP:  state_d = S_POLL_ACCESS;
            S_POLL_ACCESS: if (x_done) state_d = S_CHECK;
            S_CHECK: begin
                if (poll_ok) begin
                    status_d = RSP_OK;
                    state_d  = S_DONE;
                end else if (tmo_hit) begin
                    status_d = RSP_TIMEOUT;
                    state_d  = S_DONE;
                end else if (POLL_GAP == 0) begin
                    x_start = 1'b1;
                    state_d = S_POLL_SETUP;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == 16'd0) begin
                    x_start = 1'b1;
                    state_d = S_POLL_SETUP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            op_q     <= OP_NONE;
            status_q <= RSP_OK;
            tmo_q    <= '0;
            gap_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            if (state_q == S_IDLE) begin
                if (cmd_valid) begin
                    op_q  <= cmd_op;
                    tmo_q <= '0;
                end
            end else if (tmo_q != '1) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (state_q == S_CHECK) begin
                gap_q <= 16'(POLL_GAP - 1);
            end else if (state_q == S_GAP && gap_q != 16'd0) begin
                gap_q <= gap_q - 16'd1;
            end
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign rsp_valid  = (state_q == S_DONE);
    assign rsp_status = (state_q == S_DONE) ? status_q : RSP_OK;

endmodule

// File: tb/tb_halt_sequencer.sv
// tb/tb_halt_sequencer.sv - directed self-checking bench for halt_sequencer
module tb_halt_sequencer;
    import halt_seq_pkg::*;

    localparam int TMO = 64;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic       busy;

    halt_sequencer_if apb();

    halt_sequencer #(
        .STATUS_ADDR    (5'h00),
        .TIMEOUT_CYCLES (TMO),
        .POLL_GAP       (2)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (cmd_ready),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status),
        .busy       (busy),
        .m          (apb)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Status register slave model: reloads on load_seq change, takes v1 on a write, v2 after delay.
    int         load_seq  = 0;
    int         seen_seq  = 0;
    logic [7:0] stat      = 8'h00;
    logic [7:0] cfg_init  = 8'h00;
    logic [7:0] cfg_v1    = 8'h00;
    logic [7:0] cfg_v2    = 8'h00;
    int         cfg_delay = 0;
    int         cfg_wait  = 0;
    int         wait_left = 0;
    int         arm_cnt   = 0;
    bit         arm       = 1'b0;

    always @(negedge PCLK) begin
        if (load_seq != seen_seq) begin
            seen_seq = load_seq;
            stat     = cfg_init;
            arm      = 1'b0;
        end
        if (arm) begin
            if (arm_cnt == 0) begin
                stat = cfg_v2;
                arm  = 1'b0;
            end else begin
                arm_cnt = arm_cnt - 1;
            end
        end
        if (apb.M_PSEL && apb.M_PENABLE) begin
            apb.M_PREADY = (wait_left == 0);
            if (wait_left != 0) wait_left = wait_left - 1;
        end else begin
            apb.M_PREADY = 1'b1;
            wait_left    = cfg_wait;
        end
        if (apb.M_PSEL && apb.M_PENABLE && apb.M_PREADY && apb.M_PWRITE) begin
            stat    = cfg_v1;
            arm     = 1'b1;
            arm_cnt = cfg_delay;
        end
        apb.M_PRDATA = apb.M_PREADY ? stat : 8'hFF;
    end

    int         cyc      = 0;
    int         psel_cnt = 0;
    int         wr_cnt   = 0;
    int         rd_cnt   = 0;
    int         addr_err = 0;
    logic [7:0] wr_last  = 8'h00;
    logic [7:0] rd_last  = 8'h00;

    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (apb.M_PSEL) begin
            psel_cnt <= psel_cnt + 1;
            if (apb.M_PADDR !== 5'h00) addr_err <= addr_err + 1;
        end
        if (apb.M_PSEL && apb.M_PENABLE && apb.M_PREADY) begin
            if (apb.M_PWRITE) begin
                wr_cnt  <= wr_cnt + 1;
                wr_last <= apb.M_PWDATA;
            end else begin
                rd_cnt  <= rd_cnt + 1;
                rd_last <= apb.M_PRDATA;
            end
        end
    end

    task automatic load_slave(input logic [7:0] init, input logic [7:0] v1, input logic [7:0] v2,
                              input int delay, input int waits);
        cfg_init  = init;
        cfg_v1    = v1;
        cfg_v2    = v2;
        cfg_delay = delay;
        cfg_wait  = waits;
        load_seq  = load_seq + 1;
        repeat (2) @(negedge PCLK);
    endtask

    // Issues one command from a negedge with cmd_ready high; returns at the rsp_valid negedge.
    task automatic run_cmd(input logic [1:0] op, output logic [1:0] st, output int lat, output bit got);
        int a;
        got = 1'b0;
        st  = 2'b11;
        lat = -1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_op    = OP_NONE;
        a = cyc;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                st  = rsp_status;
                lat = cyc - a + 1;
                break;
            end
            @(negedge PCLK);
        end
    endtask

    task automatic test_reset();
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NONE;
        repeat (3) @(negedge PCLK);
        n_checks++; if (apb.M_PSEL !== 1'b0) begin n_fail++; $display("FAIL reset_psel: got %b want 0", apb.M_PSEL); end
        n_checks++; if (apb.M_PENABLE !== 1'b0) begin n_fail++; $display("FAIL reset_penable: got %b want 0", apb.M_PENABLE); end
        n_checks++; if (apb.M_PWRITE !== 1'b0) begin n_fail++; $display("FAIL reset_pwrite: got %b want 0", apb.M_PWRITE); end
        n_checks++; if (apb.M_PWDATA !== 8'h00) begin n_fail++; $display("FAIL reset_pwdata: got %h want 00", apb.M_PWDATA); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_status !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_status: got %b want 00", rsp_status); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        PRESET = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic test_halt_already();
        logic [1:0] st; int lat; bit got; int w0, r0;
        load_slave(8'h0B, 8'h0A, 8'h0A, 0, 0);
        w0 = wr_cnt; r0 = rd_cnt;
        run_cmd(OP_HALT, st, lat, got);
        n_checks++; if (!got) begin n_fail++; $display("FAIL halt_already_rsp: no rsp_valid within bound"); end
        n_checks++; if (st !== RSP_OK) begin n_fail++; $display("FAIL halt_already_status: got %b want 00", st); end
        n_checks++; if (lat != 7) begin n_fail++; $display("FAIL halt_already_latency: got %0d want 7", lat); end
        n_checks++; if (wr_cnt - w0 != 0) begin n_fail++; $display("FAIL halt_already_writes: got %0d want 0", wr_cnt - w0); end
        n_checks++; if (rd_cnt - r0 != 2) begin n_fail++; $display("FAIL halt_already_reads: got %0d want 2", rd_cnt - r0); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] st; int lat; bit got;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_in_done: got %b want 1", busy); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_done: got %b want 0", cmd_ready); end
        @(negedge PCLK);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_rsp: got %b want 1", cmd_ready); end
        run_cmd(OP_HALT, st, lat, got);
        n_checks++; if (!got || st !== RSP_OK) begin n_fail++; $display("FAIL b2b_status: got %b (rsp %0d) want 00", st, got); end
        n_checks++; if (lat != 7) begin n_fail++; $display("FAIL b2b_latency: got %0d want 7", lat); end
        @(negedge PCLK);
    endtask

    task automatic test_halt_from_running();
        logic [1:0] st; int lat; bit got; int w0, r0;
        load_slave(8'h00, 8'h01, 8'h0B, 10, 0);
        w0 = wr_cnt; r0 = rd_cnt;
        run_cmd(OP_HALT, st, lat, got);
        n_checks++; if (!got || st !== RSP_OK) begin n_fail++; $display("FAIL halt_run_status: got %b (rsp %0d) want 00", st, got); end
        n_checks++; if (wr_cnt - w0 != 1) begin n_fail++; $display("FAIL halt_run_writes: got %0d want 1", wr_cnt - w0); end
        n_checks++; if (wr_last !== 8'h01) begin n_fail++; $display("FAIL halt_run_wdata: got %h want 01", wr_last); end
        n_checks++; if (rd_last !== 8'h0B) begin n_fail++; $display("FAIL halt_run_last_poll: got %h want 0B", rd_last); end
        n_checks++; if (rd_cnt - r0 < 4) begin n_fail++; $display("FAIL halt_run_polls: got %0d reads want >=4", rd_cnt - r0); end
        n_checks++; if (lat < 17) begin n_fail++; $display("FAIL halt_run_latency: got %0d want >=17", lat); end
        @(negedge PCLK);
    endtask

    task automatic test_resume_timeout();
        logic [1:0] st; int lat; bit got; int w0, p0;
        load_slave(8'h0B, 8'h0A, 8'h0A, 0, 0);
        w0 = wr_cnt;
        run_cmd(OP_RESUME, st, lat, got);
        n_checks++; if (!got || st !== RSP_TIMEOUT) begin n_fail++; $display("FAIL resume_timeout_status: got %b (rsp %0d) want 01", st, got); end
        n_checks++; if (lat < TMO + 2 || lat > TMO + 7) begin n_fail++; $display("FAIL resume_timeout_latency: got %0d want %0d..%0d", lat, TMO + 2, TMO + 7); end
        n_checks++; if (wr_cnt - w0 != 1 || wr_last !== 8'h01) begin n_fail++; $display("FAIL resume_timeout_write: got %0d writes last %h want 1 of 01", wr_cnt - w0, wr_last); end
        p0 = psel_cnt;
        repeat (10) @(negedge PCLK);
        n_checks++; if (psel_cnt != p0) begin n_fail++; $display("FAIL resume_timeout_quiet: got %0d psel cycles want 0", psel_cnt - p0); end
    endtask

    task automatic test_badcmd();
        logic [1:0] st; int lat; bit got; int p0;
        p0 = psel_cnt;
        run_cmd(OP_NONE, st, lat, got);
        n_checks++; if (!got || st !== RSP_BADCMD) begin n_fail++; $display("FAIL badcmd_status: got %b (rsp %0d) want 10", st, got); end
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL badcmd_latency: got %0d want 1", lat); end
        n_checks++; if (psel_cnt != p0) begin n_fail++; $display("FAIL badcmd_psel: got %0d psel cycles want 0", psel_cnt - p0); end
        @(negedge PCLK);
    endtask

`ifdef HALTSEQ_RESET_CMD_EN
    task automatic test_reset_halt();
        logic [1:0] st; int lat; bit got; int w0, r0;
        load_slave(8'h00, 8'h07, 8'h0B, 8, 0);
        w0 = wr_cnt; r0 = rd_cnt;
        run_cmd(OP_RESET_HALT, st, lat, got);
        n_checks++; if (!got || st !== RSP_OK) begin n_fail++; $display("FAIL rsthalt_status: got %b (rsp %0d) want 00", st, got); end
        n_checks++; if (wr_cnt - w0 != 1 || wr_last !== 8'h05) begin n_fail++; $display("FAIL rsthalt_write: got %0d writes last %h want 1 of 05", wr_cnt - w0, wr_last); end
        n_checks++; if (rd_last !== 8'h0B || rd_cnt - r0 < 3) begin n_fail++; $display("FAIL rsthalt_polls: got last %h after %0d reads want 0B after >=3", rd_last, rd_cnt - r0); end
        @(negedge PCLK);
        load_slave(8'h01, 8'h07, 8'h0B, 4, 0);
        w0 = wr_cnt;
        run_cmd(OP_RESET_HALT, st, lat, got);
        n_checks++; if (!got || st !== RSP_OK) begin n_fail++; $display("FAIL rsthalt_req_set_status: got %b (rsp %0d) want 00", st, got); end
        n_checks++; if (wr_cnt - w0 != 1 || wr_last !== 8'h04) begin n_fail++; $display("FAIL rsthalt_req_set_write: got %0d writes last %h want 1 of 04", wr_cnt - w0, wr_last); end
        @(negedge PCLK);
    endtask
`else
    task automatic test_op11_disabled();
        logic [1:0] st; int lat; bit got; int p0;
        load_slave(8'h00, 8'h07, 8'h0B, 4, 0);
        p0 = psel_cnt;
        run_cmd(OP_RESET_HALT, st, lat, got);
        n_checks++; if (!got || st !== RSP_BADCMD) begin n_fail++; $display("FAIL op11_status: got %b (rsp %0d) want 10", st, got); end
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL op11_latency: got %0d want 1", lat); end
        n_checks++; if (psel_cnt != p0) begin n_fail++; $display("FAIL op11_psel: got %0d psel cycles want 0", psel_cnt - p0); end
        @(negedge PCLK);
    endtask
`endif

    task automatic test_wait_states_and_reset();
        int w0, r0, p0, rsp_seen;
        bit found;
        load_slave(8'h0B, 8'h0A, 8'h0A, 0, 3);
        w0 = wr_cnt; r0 = rd_cnt;
        cmd_valid = 1'b1;
        cmd_op    = OP_RESUME;
        @(posedge PCLK);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_op    = OP_NONE;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (wr_cnt - w0 >= 1 && rd_cnt - r0 >= 2 &&
                apb.M_PSEL && apb.M_PENABLE && !apb.M_PWRITE) begin
                found = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL wait_mid_poll: no poll access reached within bound"); end
        n_checks++; if (rd_last !== 8'h0A) begin n_fail++; $display("FAIL wait_poll_rdata: got %h want 0A", rd_last); end
        n_checks++; if (wr_cnt - w0 != 1 || wr_last !== 8'h01) begin n_fail++; $display("FAIL wait_write: got %0d writes last %h want 1 of 01", wr_cnt - w0, wr_last); end
        PRESET = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        n_checks++; if (apb.M_PSEL !== 1'b0 || apb.M_PENABLE !== 1'b0) begin n_fail++; $display("FAIL midreset_apb: got psel %b penable %b want 0 0", apb.M_PSEL, apb.M_PENABLE); end
        n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got ready %b busy %b want 1 0", cmd_ready, busy); end
        PRESET = 1'b0;
        p0 = psel_cnt;
        rsp_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) rsp_seen++;
            @(negedge PCLK);
        end
        n_checks++; if (rsp_seen != 0 || psel_cnt != p0) begin n_fail++; $display("FAIL midreset_quiet: got %0d rsp %0d psel want 0 0", rsp_seen, psel_cnt - p0); end
    endtask

    initial begin
        test_reset();
        test_halt_already();
        test_back_to_back();
        test_halt_from_running();
        test_resume_timeout();
        test_badcmd();
`ifdef HALTSEQ_RESET_CMD_EN
        test_reset_halt();
`else
        test_op11_disabled();
`endif
        test_wait_states_and_reset();
        n_checks++; if (addr_err != 0) begin n_fail++; $display("FAIL paddr: got %0d bad-address cycles want 0", addr_err); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/halt_sequencer.md
Name: halt_sequencer

Overview:
- APB master that sequences the debug status register to halt, resume, or reset-and-halt the target core.
- Converts a one-shot command into read-modify-write plus polling APB transfers.
- Hides the register's toggle-on-write semantics behind an idempotent command interface.
- Sits between the debug host command logic and the status register's APB slave port.

Parameters:
- STATUS_ADDR, 5'h00, APB address of the status register.
- TIMEOUT_CYCLES, 1024, cycles allowed from command accept to poll success.
- POLL_GAP, 4, idle cycles (PSEL=0) between consecutive unsatisfied poll reads; 0 is legal.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_op  in  2  00 none/illegal, 01 HALT, 10 RESUME, 11 RESET_HALT
- cmd_ready  out  1  high only in IDLE
- rsp_valid  out  1  one-cycle completion pulse
- rsp_status  out  2  00 OK, 01 TIMEOUT, 10 BADCMD; valid with rsp_valid
- busy  out  1  high in every state except IDLE
- M_PSEL, M_PENABLE, M_PWRITE  out  1 each  APB master controls
- M_PADDR  out  5  always STATUS_ADDR
- M_PWDATA  out  8  write data
- M_PRDATA  in  8  bit0 DEBUG_REQUEST, bit1 DEBUG_ACK, bit2 RESET_REQUEST, bit3 HALTED
- M_PREADY  in  1  slave ready

Behaviour:
Interface decision:
- One clock, PCLK.
- Reset PRESET is synchronous and active-high.
Reset state:
- State IDLE; M_PSEL, M_PENABLE, M_PWRITE, M_PWDATA, rsp_valid, rsp_status, busy all 0; timeout counter 0.
- Reset mid-operation abandons any APB transfer immediately (PSEL drops on the next edge); no response is issued.
Command acceptance:
- A command is accepted on cmd_valid & cmd_ready.
- The accepted op is latched and the timeout counter cleared.
- cmd_op=00 -> DONE with BADCMD next cycle; no APB traffic.
APB protocol:
- Setup cycle: PSEL=1, PENABLE=0.
- Access cycle: PSEL=1, PENABLE=1, held while M_PREADY=0.
- M_PRDATA is sampled on the access cycle with M_PREADY=1.
- PWRITE and PWDATA are stable across setup and access.
- After every transfer, PSEL returns to 0 for at least one cycle.
States:
- IDLE -> RD_SETUP -> RD_ACCESS -> DECIDE -> (WR_SETUP -> WR_ACCESS) -> POLL_SETUP -> POLL_ACCESS -> CHECK -> (GAP -> POLL_SETUP) | DONE -> IDLE.
DECIDE, from the initial read value r:
- HALT: write 8'h01 only if r[0]=0.
- RESUME: write 8'h01 only if r[0]=1.
- RESET_HALT: always write 8'h04 | {7'b0, ~r[0]}, which sets the debug request and starts the reset pulse in one transfer.
- If no write is needed, go straight to POLL_SETUP.
CHECK success conditions on the poll value p:
- HALT: p[1]&p[3].
- RESUME: ~p[1].
- RESET_HALT: ~p[2]&p[1]&p[3].
- On success -> DONE with OK.
Timeout:
- Counter increments every cycle from accept and saturates.
- In CHECK, unsatisfied and counter >= TIMEOUT_CYCLES -> DONE with TIMEOUT.
- No corrective write is made on timeout; the debug request is left as is.
- Otherwise -> GAP for POLL_GAP cycles (skipped if 0).
DONE:
- rsp_valid=1 for exactly one cycle, then IDLE.
- The earliest next accept is the cycle after rsp_valid.
Minimum latency:
- HALT on an already-halted core: read (2) + DECIDE + poll (2) + CHECK + DONE = rsp_valid 7 cycles after accept, with M_PREADY held high.

Optional Feature:
- HALTSEQ_RESET_CMD_EN
- Defined: RESET_HALT (op 11) behaves as described above.
- Undefined: op 11 is treated like op 00: BADCMD, no APB traffic. The RESET_HALT decode and check logic is not built.

Decomposition:
- Package halt_seq_pkg holds:
  - the state enum;
  - the cmd_op and rsp_status encodings;
  - the status bit indices (DBG_REQ=0, DBG_ACK=1, RST_REQ=2, HALTED=3);
  - the write constants TOGGLE_DBG=8'h01 and PULSE_RST=8'h04.
- One sub-module, apb_xfer: a single-transfer APB master engine (start, write, wdata -> done, rdata). It is reused for the initial read, the write and the polls. The controller FSM stays in the top module.

Test Plan:
- HALT, slave initially 8'h00, DEBUG_ACK and HALTED rise 10 cycles after the write -> exactly one write of 8'h01; polls until 8'h0B; rsp OK.
- HALT, slave already 8'h0B -> no write transfer; rsp OK at accept+7 with PREADY=1.
- RESUME from 8'h0B, ACK never drops, TIMEOUT_CYCLES=64 -> one write of 8'h01; rsp TIMEOUT with a counter value >= 64; no further writes.
- RESET_HALT from 8'h00 -> write 8'h05; polls 8'h07 (reset active) rejected; success on 8'h0B.
- RESET_HALT from 8'h01 -> write 8'h04 (no toggle-off).
- Without the macro, op 11 -> BADCMD next cycle; M_PSEL stays 0.
- M_PREADY low for 3 cycles on every access; PRESET asserted mid-poll -> access extended; rdata sampled only with PREADY=1; after reset, PSEL=0 and IDLE on the next edge, cmd_ready=1, no rsp_valid.
